// File: rtl/pipelined_functional_unit_if.sv
// Issue and wakeup signal bundle for pipelined_functional_unit.
// master: issue/consumer side, slave: the functional unit.
`timescale 1ns/1ps
interface pipelined_functional_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned ROB_WIDTH  = 6
);
    logic                  write_enable;
    logic [3:0]            ALUControl;
    logic                  ALUSrc;
    logic                  is_for_lsq;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] rs1_value;
    logic [DATA_WIDTH-1:0] rs2_value;
    logic [TAG_WIDTH-1:0]  tag_to_output;
    logic [ROB_WIDTH-1:0]  rob_index;
    logic                  is_available;
    logic                  wakeup_active;
    logic                  wakeup_ready;
    logic [ROB_WIDTH-1:0]  wakeup_rob_index;
    logic [TAG_WIDTH-1:0]  wakeup_tag;
    logic [DATA_WIDTH-1:0] wakeup_value;
    logic                  lsq_wakeup_active;
    logic                  lsq_wakeup_ready;
    logic [ROB_WIDTH-1:0]  lsq_wakeup_rob_index;
    logic [DATA_WIDTH-1:0] lsq_wakeup_value;

    modport master (
        output write_enable, ALUControl, ALUSrc, is_for_lsq, imm, rs1_value, rs2_value,
               tag_to_output, rob_index, wakeup_ready, lsq_wakeup_ready,
        input  is_available, wakeup_active, wakeup_rob_index, wakeup_tag, wakeup_value,
               lsq_wakeup_active, lsq_wakeup_rob_index, lsq_wakeup_value
    );

    modport slave (
        input  write_enable, ALUControl, ALUSrc, is_for_lsq, imm, rs1_value, rs2_value,
               tag_to_output, rob_index, wakeup_ready, lsq_wakeup_ready,
        output is_available, wakeup_active, wakeup_rob_index, wakeup_tag, wakeup_value,
               lsq_wakeup_active, lsq_wakeup_rob_index, lsq_wakeup_value
    );
endinterface

// File: rtl/pipelined_functional_unit.sv
// Pipelined ALU: LATENCY-cycle compute, credit-guarded result FIFO, RS/ROB or LSQ wakeup.
// Optional macro FU_FLUSH_EN adds a flush input that kills all pipeline and buffered work.
`timescale 1ns/1ps
module pipelined_functional_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 6,
    parameter int unsigned ROB_WIDTH   = 6,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input logic clk,
    input logic reset,
`ifdef FU_FLUSH_EN
    input logic flush,
`endif
    pipelined_functional_unit_if.slave bus
);
    localparam int unsigned STAGES = LATENCY - 1;
    localparam int unsigned SHW    = $clog2(DATA_WIDTH);
    localparam int unsigned CNTW   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OCCW   = $clog2(QUEUE_DEPTH + LATENCY + 1);

    typedef struct packed {
        logic                  lsq;
        logic [ROB_WIDTH-1:0]  rob;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] value;
    } entry_t;

    function automatic logic [DATA_WIDTH-1:0] alu_result(input logic [3:0] op,
                                                         input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
        logic [SHW-1:0]        shamt;
        logic [DATA_WIDTH-1:0] r;
        shamt = b[SHW-1:0];
        r = '0;
        case (op)
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a & b;
            4'b0100: r = a ^ b;
            4'b0110: r = a - b;
            4'b0111: r[0] = $signed(a) < $signed(b);
            4'b1000: r = a << shamt;
            4'b1001: r = a >> shamt;
            4'b1010: r = $unsigned($signed(a) >>> shamt);
            4'b1011: r[0] = a < b;
            4'b1100: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    entry_t            pipe_q       [STAGES];
    entry_t            pipe_d       [STAGES];
    logic              pipe_valid_q [STAGES];
    logic              pipe_valid_d [STAGES];
    entry_t            buf_q        [QUEUE_DEPTH];
    entry_t            buf_d        [QUEUE_DEPTH];
    logic [CNTW-1:0]   count_q, count_d;
    logic [OCCW-1:0]   occupancy;
    logic              avail, accept, is_nop, nop_write, exit_valid, head_valid, pop;
    entry_t            issue_entry, head;
    int unsigned       wr_idx;

    always_comb begin
        occupancy = OCCW'(count_q);
        for (int unsigned i = 0; i < STAGES; i++) occupancy = occupancy + OCCW'(pipe_valid_q[i]);
        // Credit counts only registered state, so a same-edge pop never frees a slot early.
        avail      = occupancy < OCCW'(QUEUE_DEPTH);
        accept     = bus.write_enable && avail;
        is_nop     = bus.ALUControl == 4'b0000;
        nop_write  = accept && is_nop;
        exit_valid = pipe_valid_q[STAGES-1];
        head       = buf_q[0];
        head_valid = count_q != '0;
        pop        = head_valid && (head.lsq ? bus.lsq_wakeup_ready : bus.wakeup_ready);

        issue_entry.lsq   = bus.is_for_lsq;
        issue_entry.rob   = bus.rob_index;
        issue_entry.tag   = bus.tag_to_output;
        issue_entry.value = alu_result(bus.ALUControl, bus.rs1_value,
                                       bus.ALUSrc ? bus.imm : bus.rs2_value);

        pipe_d[0]       = issue_entry;
        pipe_valid_d[0] = accept && !is_nop;
        for (int unsigned i = 1; i < STAGES; i++) begin
            pipe_d[i]       = pipe_q[i-1];
            pipe_valid_d[i] = pipe_valid_q[i-1];
        end

        // Buffer is kept compacted at index 0: pop shifts down, then up to two appends.
        buf_d = buf_q;
        if (pop) begin
            for (int unsigned i = 0; i + 1 < QUEUE_DEPTH; i++) buf_d[i] = buf_q[i+1];
            buf_d[QUEUE_DEPTH-1] = '0;
        end
        wr_idx = 32'(count_q) - (pop ? 32'd1 : 32'd0);
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (exit_valid && i == wr_idx) buf_d[i] = pipe_q[STAGES-1];
            if (nop_write && i == wr_idx + (exit_valid ? 32'd1 : 32'd0)) buf_d[i] = issue_entry;
        end
        count_d = CNTW'(wr_idx + (exit_valid ? 32'd1 : 32'd0) + (nop_write ? 32'd1 : 32'd0));

`ifdef FU_FLUSH_EN
        if (flush) begin
            for (int unsigned i = 0; i < STAGES; i++) pipe_valid_d[i] = 1'b0;
            count_d = '0;
        end
`endif

        bus.is_available         = avail;
        bus.wakeup_active        = head_valid && !head.lsq;
        bus.wakeup_rob_index     = bus.wakeup_active ? head.rob : '0;
        bus.wakeup_tag           = bus.wakeup_active ? head.tag : '0;
        bus.wakeup_value         = bus.wakeup_active ? head.value : '0;
        bus.lsq_wakeup_active    = head_valid && head.lsq;
        bus.lsq_wakeup_rob_index = bus.lsq_wakeup_active ? head.rob : '0;
        bus.lsq_wakeup_value     = bus.lsq_wakeup_active ? head.value : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_q[i]       <= '0;
            end
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_q       <= pipe_d;
            buf_q        <= buf_d;
        end
    end
endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Self-checking bench for pipelined_functional_unit: directed plan steps plus randomized
// traffic compared against a queue-based completion-time model.
`timescale 1ns/1ps
module tb_pipelined_functional_unit;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic clk = 1'b0;
    logic reset;
`ifdef FU_FLUSH_EN
    logic flush = 1'b0;
`endif
    always #5 clk = ~clk;

    pipelined_functional_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(6), .ROB_WIDTH(6)) bus();

    pipelined_functional_unit #(
        .DATA_WIDTH(32), .TAG_WIDTH(6), .ROB_WIDTH(6), .LATENCY(LAT), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef FU_FLUSH_EN
        .flush(flush),
`endif
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] due;
        logic        lsq;
        logic [5:0]  rob;
        logic [5:0]  tag;
        logic [31:0] val;
    } op_t;

    op_t         pend[$];
    op_t         fifo[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a & b;
            4'd4:    return a ^ b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return a << sh;
            4'd9:    return a >> sh;
            4'd10:   return 32'($signed(a) >>> sh);
            4'd11:   return (a < b) ? 32'd1 : 32'd0;
            4'd12:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        op_t  h;
        logic hv;
        hv = fifo.size() > 0;
        h  = hv ? fifo[0] : '0;
        chk("is_available", 64'(bus.is_available), 64'((fifo.size() + pend.size()) < QD));
        chk("wakeup_active", 64'(bus.wakeup_active), 64'(hv && !h.lsq));
        chk("wakeup_rob", 64'(bus.wakeup_rob_index), (hv && !h.lsq) ? 64'(h.rob) : 64'd0);
        chk("wakeup_tag", 64'(bus.wakeup_tag), (hv && !h.lsq) ? 64'(h.tag) : 64'd0);
        chk("wakeup_value", 64'(bus.wakeup_value), (hv && !h.lsq) ? 64'(h.val) : 64'd0);
        chk("lsq_active", 64'(bus.lsq_wakeup_active), 64'(hv && h.lsq));
        chk("lsq_rob", 64'(bus.lsq_wakeup_rob_index), (hv && h.lsq) ? 64'(h.rob) : 64'd0);
        chk("lsq_value", 64'(bus.lsq_wakeup_value), (hv && h.lsq) ? 64'(h.val) : 64'd0);
    endtask

    task automatic drive_op(input logic [3:0] c, input logic src, input logic lsq,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                            input logic [5:0] tg, input logic [5:0] rb);
        bus.write_enable  = 1'b1;
        bus.ALUControl    = c;
        bus.ALUSrc        = src;
        bus.is_for_lsq    = lsq;
        bus.rs1_value     = a;
        bus.rs2_value     = b;
        bus.imm           = im;
        bus.tag_to_output = tg;
        bus.rob_index     = rb;
    endtask

    task automatic idle();
        bus.write_enable = 1'b0;
    endtask

    // One clock edge: decide accept/pop from model state, advance the model, then check.
    task automatic tick();
        logic acc, pop, fl;
        op_t  o;
        acc = bus.write_enable && ((fifo.size() + pend.size()) < QD);
        pop = (fifo.size() > 0) && (fifo[0].lsq ? bus.lsq_wakeup_ready : bus.wakeup_ready);
        fl  = 1'b0;
`ifdef FU_FLUSH_EN
        fl  = flush;
`endif
        o.lsq = bus.is_for_lsq;
        o.rob = bus.rob_index;
        o.tag = bus.tag_to_output;
        o.val = ref_alu(bus.ALUControl, bus.rs1_value, bus.ALUSrc ? bus.imm : bus.rs2_value);
        o.due = 32'd0;
        @(posedge clk);
        cyc++;
        if (fl) begin
            fifo.delete();
            pend.delete();
        end else begin
            if (pop) void'(fifo.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) fifo.push_back(pend.pop_front());
            if (acc) begin
                if (bus.ALUControl == 4'd0) fifo.push_back(o);
                else begin
                    o.due = cyc + LAT - 1;
                    pend.push_back(o);
                end
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.wakeup_ready = 1'b0;
        bus.lsq_wakeup_ready = 1'b0;
        drive_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_avail", 64'(bus.is_available), 64'd1);
        reset = 1'b1;
        tick();

        // NOP with empty buffer shows up right after its accept edge
        bus.wakeup_ready = 1'b1;
        bus.lsq_wakeup_ready = 1'b1;
        drive_op(4'd0, 1'b0, 1'b0, 32'd11, 32'd22, 32'd0, 6'd0, 6'd2);
        tick();
        chk("nop_active", 64'(bus.wakeup_active), 64'd1);
        chk("nop_rob", 64'(bus.wakeup_rob_index), 64'd2);
        chk("nop_value", 64'(bus.wakeup_value), 64'd0);
        idle();
        tick();
        chk("nop_drained", 64'({bus.wakeup_active, bus.lsq_wakeup_active}), 64'd0);

        // ADD, LATENCY=2
        drive_op(4'd2, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 6'd4, 6'd3);
        tick();
        chk("add_avail_0", 64'(bus.is_available), 64'd1);
        idle();
        tick();
        chk("add_value", 64'(bus.wakeup_value), 64'd5);
        chk("add_tag", 64'(bus.wakeup_tag), 64'd4);
        chk("add_rob", 64'(bus.wakeup_rob_index), 64'd3);
        chk("add_avail_1", 64'(bus.is_available), 64'd1);
        tick();

        // SUB then SRA on the LSQ path, back to back
        drive_op(4'd6, 1'b0, 1'b0, 32'd7, 32'd9, 32'd0, 6'd1, 6'd4);
        tick();
        drive_op(4'd10, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 6'd2, 6'd5);
        tick();
        chk("sub_value", 64'(bus.wakeup_value), 64'hFFFF_FFFE);
        idle();
        tick();
        chk("sra_active", 64'(bus.lsq_wakeup_active), 64'd1);
        chk("sra_value", 64'(bus.lsq_wakeup_value), 64'hF800_0000);
        tick();

        // Fill all credits with readies low, hold, then drain
        bus.wakeup_ready = 1'b0;
        bus.lsq_wakeup_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_op(4'd2, 1'b0, 1'b0, 32'(k), 32'(100 + k), 32'd0, 6'(8 + k), 6'(16 + k));
            tick();
        end
        chk("full_avail", 64'(bus.is_available), 64'd0);
        drive_op(4'd12, 1'b0, 1'b0, 32'd0, 32'd77, 32'd0, 6'd63, 6'd63);
        repeat (3) tick();
        idle();
        chk("held_value", 64'(bus.wakeup_value), 64'd100);
        bus.wakeup_ready = 1'b1;
        tick();
        chk("drain1_value", 64'(bus.wakeup_value), 64'd102);
        chk("drain1_avail", 64'(bus.is_available), 64'd1);
        repeat (4) tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 75)
                drive_op(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                         $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
                         32'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)));
            else
                idle();
            bus.wakeup_ready     = $urandom_range(99) < 70;
            bus.lsq_wakeup_ready = $urandom_range(99) < 70;
            tick();
        end

        // Asynchronous reset mid-traffic discards everything
        bus.wakeup_ready = 1'b0;
        bus.lsq_wakeup_ready = 1'b0;
        drive_op(4'd2, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 6'd1, 6'd1);
        tick();
        tick();
        reset = 1'b0;
        fifo.delete();
        pend.delete();
        #1;
        check_outputs();
        idle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_outputs();
        bus.wakeup_ready = 1'b1;
        bus.lsq_wakeup_ready = 1'b1;
        repeat (3) tick();

`ifdef FU_FLUSH_EN
        bus.wakeup_ready = 1'b0;
        bus.lsq_wakeup_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_op(4'd2, 1'b0, 1'($urandom_range(1)), 32'(k), 32'd5, 32'd0, 6'(k), 6'(k));
            tick();
        end
        flush = 1'b1;
        drive_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd9, 6'd9);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_active", 64'({bus.wakeup_active, bus.lsq_wakeup_active}), 64'd0);
        chk("flush_avail", 64'(bus.is_available), 64'd1);
        bus.wakeup_ready = 1'b1;
        bus.lsq_wakeup_ready = 1'b1;
        repeat (10) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_functional_unit.md
# pipelined_functional_unit

Parametrised, pipelined successor to the single-op functional unit: accepts one ALU op per cycle, computes it over a configurable LATENCY, and queues results in a small output buffer. The buffer drains onto either the reservation-station/ROB wakeup bus or the LSQ wakeup bus under a ready/active handshake. It sits between issue (reservation stations) and the wakeup/CDB arbiters. It replaces the one-op-in-flight unit so back-to-back independent ops no longer stall.

## Interface
- DATA_WIDTH, 32, operand/result width (32 or 64)
- TAG_WIDTH, 6, physical-register tag width
- ROB_WIDTH, 6, ROB index width
- LATENCY, 2, edges from accept to result for non-NOP ops (≥2)
- QUEUE_DEPTH, 4, result-buffer entries; also the max ops in flight plus buffered (≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- write_enable  in  1  issue request
- ALUControl  in  4  operation select
- ALUSrc  in  1  0: B=rs2_value, 1: B=imm
- is_for_lsq  in  1  route result to LSQ bus
- imm, rs1_value, rs2_value  in  DATA_WIDTH each  operands
- tag_to_output  in  TAG_WIDTH  destination tag
- rob_index  in  ROB_WIDTH  ROB entry
- flush  in  1  kill all work (only with FU_FLUSH_EN)
- is_available  out  1  op will be accepted this cycle
- wakeup_active  out  1  head result valid, RS/ROB bound
- wakeup_ready  in  1  RS/ROB bus takes head
- wakeup_rob_index  out  ROB_WIDTH
- wakeup_tag  out  TAG_WIDTH
- wakeup_value  out  DATA_WIDTH
- lsq_wakeup_active  out  1  head result valid, LSQ bound
- lsq_wakeup_ready  in  1  LSQ bus takes head
- lsq_wakeup_rob_index  out  ROB_WIDTH
- lsq_wakeup_value  out  DATA_WIDTH

## Operation
- ALUControl (A=rs1_value):
  - 0000 NOP (value 0); 0001 OR; 0010 ADD; 0011 AND; 0100 XOR; 0110 SUB; 0111 SLT (signed)
  - 1000 SLL; 1001 SRL; 1010 SRA; shift amount is B[$clog2(DATA_WIDTH)-1:0]
  - 1011 SLTU; 1100 pass B; all other codes yield 0
- Arithmetic wraps modulo 2^DATA_WIDTH. SLT/SLTU return zero-extended 0/1.
- Accept = write_enable && is_available. When !is_available, write_enable is ignored.
- is_available = (buffer_count + in_flight) < QUEUE_DEPTH. It is combinational from registered state only; same-cycle pops are not credited. An accepted op reserves a slot, so the buffer never overflows.
- NOP: written into the buffer at its accept edge.
- Other ops: travel LATENCY-1 pipeline stages, then are written into the buffer.
- Buffer is a FIFO. Up to 2 writes and 1 pop per edge. If a pipeline exit and a NOP accept land on the same edge, the pipeline result is written first.
- Head routing:
  - is_for_lsq=0: drives wakeup_*; lsq_wakeup_active=0.
  - is_for_lsq=1: drives lsq_wakeup_*; wakeup_active=0.
- Pop on (wakeup_active && wakeup_ready) || (lsq_wakeup_active && lsq_wakeup_ready).
- An unaccepted head holds its active flag and all fields stable.
- Inactive outputs drive index/tag/value = 0.
- Completion order is not issue order: a NOP may overtake an older ADD. Consumers key on tag/rob_index.

## Timing
- Reset (asynchronous, while low): buffer empty, pipeline invalid.
  - wakeup_active=0, lsq_wakeup_active=0, all index/tag/value outputs 0.
  - is_available=1.
- Reset mid-operation discards all in-flight and buffered ops with no output.
- NOP accepted at edge E: visible on outputs after E (empty buffer).
- Non-NOP accepted at edge E: visible after edge E+LATENCY-1 (empty buffer).
- Throughput: one accept per cycle while the credit rule holds.
- Pop at edge P: the next head is visible after P.
- Full credit (count+in_flight == QUEUE_DEPTH): is_available=0. It returns to 1 the cycle after the edge that pops.

## Configuration
- FU_FLUSH_EN defined:
  - `flush` port exists.
  - At an edge with flush=1, all pipeline stages and buffer entries are invalidated and any same-cycle accept is dropped.
  - After that edge, both active outputs are 0 and is_available=1.
- FU_FLUSH_EN undefined:
  - No `flush` port.
  - Only reset clears state.

## Test plan
- Reset low then high, no issue: is_available=1, both active=0, all fields 0.
- NOP, tag 0, rob 2, readies=1: after the accept edge, wakeup_active=1, tag 0, rob 2, value 0. Next cycle both active=0.
- ADD rs1=2 rs2=3 ALUSrc=0 tag 4 rob 3, LATENCY=2, wakeup_ready=1: one edge later, wakeup value 5, tag 4, rob 3. is_available stays 1 throughout.
- Back-to-back SUB (7-9) then SRA (0x80000000>>>4 via imm=4, is_for_lsq=1): both paths complete.
  - Consecutive cycles: wakeup_value=0xFFFFFFFE, then lsq_wakeup_value=0xF8000000.
- Both readies held 0, issue 4 ADDs: is_available=0 after the 4th accept.
  - Results held stable.
  - Raising wakeup_ready drains one result per cycle in order; is_available returns to 1.
- FU_FLUSH_EN: flush=1 with 3 ops buffered or in flight: both active=0 after the edge, is_available=1, no late wakeups within 10 cycles.
